// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: frame-coherent shadow data,
// hex decode with leading-zero suppression, per-digit blank, decimal point and blink.
module seg7_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SLOT_CYCLES  = 100000,
    parameter int DEAD_CYCLES  = 2000,
    parameter int BLINK_FRAMES = 64,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  iLoad,
    input  logic [4*DIGITS-1:0]   iData,
    input  logic [DIGITS-1:0]     iBlank,
    input  logic [DIGITS-1:0]     iDp,
    input  logic [DIGITS-1:0]     iBlink,
    output logic [DIGITS-1:0]     oAn,
    output logic [6:0]            oSeg,
    output logic                  oDp,
    output logic                  oBusy
);

    localparam int SLOT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SLOT_W-1:0]   slot_cnt;
    logic [IDX_W-1:0]    idx;
    logic [FRAME_W-1:0]  frame_cnt;
    logic                blink_phase;
    logic                slot_last;
    logic                idx_last;
    logic                frame_edge;
    logic                frame_last;
    logic                pending;

    logic [4*DIGITS-1:0] stage_data;
    logic [DIGITS-1:0]   stage_blank;
    logic [DIGITS-1:0]   stage_dp;
    logic [DIGITS-1:0]   stage_blink;
    logic [4*DIGITS-1:0] shadow_data;
    logic [DIGITS-1:0]   shadow_blank;
    logic [DIGITS-1:0]   shadow_dp;
    logic [DIGITS-1:0]   shadow_blink;

    logic [DIGITS-1:0]   lz;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                cur_blank;
    logic                cur_dp;
    logic                cur_blink;
    logic                cur_lz;
    logic                digit_off;
    logic                dead_done;
    logic [DIGITS-1:0]   an_p0;
    logic [6:0]          seg_p0;
    logic                dp_p0;

    logic [DIGITS-1:0]   an_p1;
    logic [6:0]          seg_p1;
    logic                dp_p1;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] blank_seg(input logic [6:0] seg, input logic off);
        return off ? 7'h7F : seg;
    endfunction

    assign slot_last  = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
    assign idx_last   = (idx == IDX_W'(DIGITS - 1));
    assign frame_edge = slot_last && idx_last;
    assign frame_last = (frame_cnt == FRAME_W'(BLINK_FRAMES - 1));

    // Scan counters keep running while ena is low so loads still land on frame edges
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt    <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (slot_last) begin
                slot_cnt <= '0;
                idx      <= idx_last ? '0 : idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            if (frame_edge) begin
                if (frame_last) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // A load coinciding with a frame edge is staged only; the older staged copy moves first
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= 1'b0;
            stage_data   <= '0;
            stage_blank  <= '0;
            stage_dp     <= '0;
            stage_blink  <= '0;
            shadow_data  <= '0;
            shadow_blank <= '0;
            shadow_dp    <= '0;
            shadow_blink <= '0;
        end else begin
            if (frame_edge && pending) begin
                shadow_data  <= stage_data;
                shadow_blank <= stage_blank;
                shadow_dp    <= stage_dp;
                shadow_blink <= stage_blink;
            end
            if (iLoad) begin
                stage_data  <= iData;
                stage_blank <= iBlank;
                stage_dp    <= iDp;
                stage_blink <= iBlink;
                pending     <= 1'b1;
            end else if (frame_edge) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        lz        = '0;
        zero_run  = 1'b1;
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        an_p0     = '1;
        // Walk from the most significant digit; a digit is a leading zero while the run holds
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (shadow_data[4*k +: 4] == 4'h0);
            lz[k]    = (LZ_SUPPRESS != 0) && (k > 0) && zero_run;
        end
        dead_done = (slot_cnt >= SLOT_W'(DEAD_CYCLES));
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = shadow_data[4*k +: 4];
                cur_blank = shadow_blank[k];
                cur_dp    = shadow_dp[k];
                cur_blink = shadow_blink[k];
                cur_lz    = lz[k];
            end
            an_p0[k] = ~(ena && dead_done && (idx == IDX_W'(k)));
        end
        digit_off = cur_blank | (cur_blink & blink_phase) | cur_lz;
        seg_p0    = blank_seg(hex_to_seg(cur_nib), digit_off);
        dp_p0     = digit_off | ~cur_dp;
    end

    // p0 -> p1: registered pin drive
    always_ff @(posedge clk) begin
        if (rst) begin
            an_p1  <= '1;
            seg_p1 <= 7'h7F;
            dp_p1  <= 1'b1;
        end else begin
            an_p1  <= an_p0;
            seg_p1 <= seg_p0;
            dp_p1  <= dp_p0;
        end
    end

    assign oAn   = an_p1;
    assign oSeg  = seg_p1;
    assign oDp   = dp_p1;
    assign oBusy = pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random loads, checked cycle by
// cycle against a model derived from cycle count, frame arithmetic and a load queue.
module tb_seg7_scan_driver;

    localparam int DIGITS       = 4;
    localparam int SLOT_CYCLES  = 4;
    localparam int DEAD_CYCLES  = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int LZ_SUPPRESS  = 1;
    localparam int FRAME        = DIGITS * SLOT_CYCLES;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        iLoad;
    logic [15:0] iData;
    logic [3:0]  iBlank;
    logic [3:0]  iDp;
    logic [3:0]  iBlink;
    logic [3:0]  oAn;
    logic [6:0]  oSeg;
    logic        oDp;
    logic        oBusy;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SLOT_CYCLES(SLOT_CYCLES), .DEAD_CYCLES(DEAD_CYCLES),
        .BLINK_FRAMES(BLINK_FRAMES), .LZ_SUPPRESS(LZ_SUPPRESS)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .iLoad(iLoad), .iData(iData),
        .iBlank(iBlank), .iDp(iDp), .iBlink(iBlink),
        .oAn(oAn), .oSeg(oSeg), .oDp(oDp), .oBusy(oBusy)
    );

    typedef struct {
        int          f;
        logic [15:0] data;
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [3:0]  blink;
    } load_t;

    load_t       q[$];
    logic [15:0] sh_data;
    logic [3:0]  sh_blank, sh_dp, sh_blink;
    logic [6:0]  seg_tab [16];
    int          s;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_busy;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic model_reset();
        q.delete();
        sh_data = '0; sh_blank = '0; sh_dp = '0; sh_blink = '0;
        s = 0;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_busy = 1'b0;
    endtask

    // Advance the model over one clock edge using the currently driven inputs
    task automatic model_edge();
        int slot, idx, phase, f;
        bit blank;
        logic [3:0] nib;
        load_t e;
        slot  = s % SLOT_CYCLES;
        idx   = (s / SLOT_CYCLES) % DIGITS;
        phase = (s / (FRAME * BLINK_FRAMES)) % 2;
        nib   = sh_data[4*idx +: 4];
        blank = sh_blank[idx] || (sh_blink[idx] && phase == 1) ||
                (LZ_SUPPRESS == 1 && idx > 0 && (sh_data >> (4*idx)) == 16'h0);
        exp_an  = (ena && slot >= DEAD_CYCLES) ? ~(4'b0001 << idx) : 4'hF;
        exp_seg = blank ? 7'h7F : seg_tab[nib];
        exp_dp  = blank ? 1'b1 : ~sh_dp[idx];
        if (iLoad) begin
            f = (s + 1) / FRAME + 1;
            while (q.size() > 0 && q[q.size()-1].f == f) void'(q.pop_back());
            e.f = f; e.data = iData; e.blank = iBlank; e.dp = iDp; e.blink = iBlink;
            q.push_back(e);
        end
        s++;
        while (q.size() > 0 && q[0].f <= s / FRAME) begin
            sh_data = q[0].data; sh_blank = q[0].blank;
            sh_dp = q[0].dp; sh_blink = q[0].blink;
            void'(q.pop_front());
        end
        exp_busy = (q.size() > 0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, s);
        end
    endtask

    task automatic check_all();
        check("oAn", {28'd0, oAn}, {28'd0, exp_an});
        check("oSeg", {25'd0, oSeg}, {25'd0, exp_seg});
        check("oDp", {31'd0, oDp}, {31'd0, exp_dp});
        check("oBusy", {31'd0, oBusy}, {31'd0, exp_busy});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        iLoad = 1'b0;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        iLoad = 1'b0;
        model_reset();
        check_all();
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] b,
                        input logic [3:0] dp, input logic [3:0] bl);
        iData = d; iBlank = b; iDp = dp; iBlink = bl; iLoad = 1'b1;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst = 1'b1; ena = 1'b0; iLoad = 1'b0;
        iData = '0; iBlank = '0; iDp = '0; iBlink = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        ena = 1'b1;
        run(2 * FRAME);

        load(16'hA3F7, 4'b0000, 4'b0100, 4'b0000);
        run(3 * FRAME);

        load(16'h0050, 4'b0000, 4'b0000, 4'b0000);
        run(2 * FRAME);

        load(16'h1111, 4'b0000, 4'b0000, 4'b0000);
        run(3);
        load(16'h2222, 4'b0000, 4'b0000, 4'b0000);
        run(2 * FRAME);

        load(16'h8888, 4'b0000, 4'b0000, 4'b0001);
        run(9 * FRAME);

        run(5);
        ena = 1'b0;
        step();
        check("ena_off_an", {28'd0, oAn}, 32'hF);
        run(FRAME);
        ena = 1'b1;

        for (int i = 0; i < FRAME; i++) begin
            if (s % FRAME == FRAME - 1) break;
            step();
        end
        load(16'h4D0C, 4'b0010, 4'b1001, 4'b0000);
        run(3 * FRAME);

        for (int i = 0; i < 800; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) begin
                iData  = 16'($urandom) >> (4 * $urandom_range(0, 4));
                iBlank = 4'($urandom & $urandom & $urandom);
                iDp    = 4'($urandom);
                iBlink = 4'($urandom & $urandom);
                iLoad  = 1'b1;
            end
            step();
        end

        ena = 1'b1;
        run(6);
        load(16'hFFFF, 4'b0000, 4'b1111, 4'b0000);
        run(2);
        do_reset();
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        run(3 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
